// File: rtl/sha512_block_loader.sv
// sha512_block_loader
// Collects 32-bit message words into a 1024-bit SHA-512 message block and
// hands the finished block to the compression core. The word index comes
// from an external 5-bit data counter; this module only clears or advances it.
module sha512_block_loader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 32,
    parameter int CNT_W     = 5
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic [WORD_W-1:0]           i_data,
    input  logic                        i_data_valid,
    output logic                        o_data_ready,
    input  logic [CNT_W-1:0]            counter_data,
    output logic                        clr_data,
    output logic                        cnt_data_en,
    output logic [NUM_WORDS*WORD_W-1:0] o_block,
    output logic                        o_block_valid,
    input  logic                        i_block_ready,
    output logic                        o_busy
);

    localparam int BLK_W = NUM_WORDS * WORD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BLK_W-1:0]   r_block;
    logic               w_write;
    logic               w_last;

    // Handshake decode, counter control and next-state selection.
    // An abort in LOAD or a reset suppresses the word write and the counter
    // increment, so clr_data and cnt_data_en are never asserted together.
    always_comb begin
        w_next        = r_state;
        o_data_ready  = 1'b0;
        o_block_valid = 1'b0;
        o_busy        = 1'b0;
        clr_data      = i_rst;
        cnt_data_en   = 1'b0;
        w_write       = 1'b0;
        w_last        = (counter_data == CNT_W'(NUM_WORDS - 1));

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    clr_data = 1'b1;
                    w_next   = LOAD;
                end
            end
            LOAD: begin
                o_data_ready = 1'b1;
                o_busy       = 1'b1;
                if (i_abort) begin
                    clr_data = 1'b1;
                    w_next   = IDLE;
                end else if (i_data_valid && !i_rst) begin
                    w_write     = 1'b1;
                    cnt_data_en = 1'b1;
                    if (w_last) begin
                        w_next = FULL;
                    end
                end
            end
            FULL: begin
                o_block_valid = 1'b1;
                o_busy        = 1'b1;
                if (i_block_ready) begin
                    clr_data = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Block buffer: each accepted word lands at its big-endian slot, word 0
    // in the most significant bits, so the core can read W[j] directly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_block <= '0;
        end else if (w_write) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (counter_data == CNT_W'(k)) begin
                    r_block[(NUM_WORDS - 1 - k) * WORD_W +: WORD_W] <= i_data;
                end
            end
        end
    end

    assign o_block = r_block;

endmodule

// File: tb/tb_sha512_block_loader.sv
// tb_sha512_block_loader
// Drives directed and random traffic into the block loader, models the
// external data-word counter, and compares every cycle against a
// transaction-level reference (array of received words plus a phase flag).
module tb_sha512_block_loader;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 32;
    localparam int CNT_W     = 5;
    localparam int BLK_W     = NUM_WORDS * WORD_W;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_start;
    logic                i_abort;
    logic [WORD_W-1:0]   i_data;
    logic                i_data_valid;
    logic                o_data_ready;
    logic [CNT_W-1:0]    counter_data;
    logic                clr_data;
    logic                cnt_data_en;
    logic [BLK_W-1:0]    o_block;
    logic                o_block_valid;
    logic                i_block_ready;
    logic                o_busy;

    // Reference model state.
    bit                  mLoading;
    bit                  mFull;
    int                  mIdx;
    logic [WORD_W-1:0]   mWords [NUM_WORDS];

    int vectors     = 0;
    int miscompares = 0;

    sha512_block_loader #(
        .WORD_W   (WORD_W),
        .NUM_WORDS(NUM_WORDS),
        .CNT_W    (CNT_W)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .counter_data (counter_data),
        .clr_data     (clr_data),
        .cnt_data_en  (cnt_data_en),
        .o_block      (o_block),
        .o_block_valid(o_block_valid),
        .i_block_ready(i_block_ready),
        .o_busy       (o_busy)
    );

    // Free-running clock.
    always #5 i_clk = ~i_clk;

    // External data-word counter: clear wins over increment.
    always_ff @(posedge i_clk) begin
        if (clr_data) begin
            counter_data <= '0;
        end else if (cnt_data_en) begin
            counter_data <= counter_data + 1'b1;
        end
    end

    task automatic check(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BLK_W-1:0] expBlock();
        logic [BLK_W-1:0] b;
        b = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            b[BLK_W - 1 - WORD_W * k -: WORD_W] = mWords[k];
        end
        return b;
    endfunction

    task automatic modelReset();
        mLoading = 1'b0;
        mFull    = 1'b0;
        mIdx     = 0;
        for (int k = 0; k < NUM_WORDS; k++) mWords[k] = '0;
    endtask

    // Compare all outputs against what the model predicts for the current inputs.
    task automatic checkOutput();
        bit idle;
        bit expClr;
        idle   = !mLoading && !mFull;
        expClr = i_rst || (idle && i_start) || (mLoading && i_abort) || (mFull && i_block_ready);
        check("o_data_ready",  BLK_W'(o_data_ready),  BLK_W'(mLoading));
        check("cnt_data_en",   BLK_W'(cnt_data_en),   BLK_W'(mLoading && i_data_valid && !i_abort && !i_rst));
        check("clr_data",      BLK_W'(clr_data),      BLK_W'(expClr));
        check("o_block_valid", BLK_W'(o_block_valid), BLK_W'(mFull));
        check("o_busy",        BLK_W'(o_busy),        BLK_W'(mLoading || mFull));
        check("counter_data",  BLK_W'(counter_data),  BLK_W'(mIdx % NUM_WORDS));
        check("o_block",       o_block,               expBlock());
    endtask

    // Advance the model across the coming clock edge.
    task automatic updateModel();
        if (i_rst) begin
            modelReset();
        end else if (!mLoading && !mFull) begin
            if (i_start) begin
                mLoading = 1'b1;
                mIdx     = 0;
            end
        end else if (mLoading) begin
            if (i_abort) begin
                mLoading = 1'b0;
                mIdx     = 0;
            end else if (i_data_valid) begin
                mWords[mIdx] = i_data;
                mIdx++;
                if (mIdx == NUM_WORDS) begin
                    mLoading = 1'b0;
                    mFull    = 1'b1;
                end
            end
        end else begin
            if (i_block_ready) begin
                mFull = 1'b0;
                mIdx  = 0;
            end
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check mid-cycle.
    task automatic applyStimulus(input bit rst, input bit start, input bit abort,
                                 input bit valid, input logic [WORD_W-1:0] data,
                                 input bit blkReady);
        @(posedge i_clk);
        #1;
        i_rst         = rst;
        i_start       = start;
        i_abort       = abort;
        i_data_valid  = valid;
        i_data        = data;
        i_block_ready = blkReady;
        #3;
        checkOutput();
        updateModel();
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, $urandom, 0);
    endtask

    task automatic loadWords(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1, $urandom, 0);
    endtask

    initial begin
        i_rst         = 1'b1;
        i_start       = 1'b0;
        i_abort       = 1'b0;
        i_data_valid  = 1'b0;
        i_data        = '0;
        i_block_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        modelReset();

        // Reset in the middle of a block at index 7.
        applyStimulus(1, 0, 0, 0, '0, 0);
        applyStimulus(0, 1, 0, 0, '0, 0);
        loadWords(7);
        applyStimulus(1, 0, 0, 1, $urandom, 0);
        applyStimulus(1, 0, 0, 1, $urandom, 0);
        idleCycle();

        // Full block on consecutive cycles, words 0..31.
        applyStimulus(0, 1, 0, 0, '0, 0);
        for (int k = 0; k < NUM_WORDS; k++) applyStimulus(0, 0, 0, 1, WORD_W'(k), 0);
        applyStimulus(0, 0, 0, 0, '0, 0);
        check("first_word_msb", BLK_W'(o_block[BLK_W-1 -: WORD_W]), BLK_W'(32'h0000_0000));
        check("last_word_lsb",  BLK_W'(o_block[WORD_W-1:0]),        BLK_W'(32'h0000_001F));
        check("block_valid_full", BLK_W'(o_block_valid), BLK_W'(1'b1));
        applyStimulus(0, 0, 0, 0, '0, 1);
        idleCycle();

        // Same stream with valid toggling every cycle.
        applyStimulus(0, 1, 0, 0, '0, 0);
        for (int i = 0; i < 2 * NUM_WORDS; i++)
            applyStimulus(0, 0, 0, (i % 2) == 0, WORD_W'(i / 2), 0);

        // Core backpressure with words and start pulses offered in FULL.
        for (int i = 0; i < 10; i++) applyStimulus(0, i % 3 == 0, i % 4 == 1, 1, $urandom, 0);
        applyStimulus(0, 0, 0, 0, '0, 1);
        idleCycle();

        // Abort at index 12 together with a valid word, then a clean block.
        applyStimulus(0, 1, 0, 0, '0, 0);
        loadWords(12);
        applyStimulus(0, 0, 1, 1, 32'hDEAD_BEEF, 0);
        idleCycle();
        applyStimulus(0, 1, 0, 0, '0, 0);
        loadWords(NUM_WORDS);
        idleCycle();
        applyStimulus(0, 0, 0, 0, '0, 1);

        // Start pulse while loading at index 5 must not clear the counter.
        idleCycle();
        applyStimulus(0, 1, 0, 0, '0, 0);
        loadWords(5);
        applyStimulus(0, 1, 0, 1, $urandom, 0);
        applyStimulus(0, 1, 0, 1, $urandom, 0);
        loadWords(NUM_WORDS - 7);
        applyStimulus(0, 0, 0, 0, '0, 1);
        idleCycle();

        // Random traffic with occasional aborts and resets.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 59) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom,
                          $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
